// File: rtl/seg14_pkg.sv
// Shared types, glyph table and parameter legality check for the 14-segment scan driver.
package seg14_pkg;

    typedef logic [15:0] seg14_t;

    // Indexed by hex nibble 0..F
    localparam seg14_t GLYPH_TABLE [16] = '{
        16'h3AB1, 16'h0290, 16'h1C70, 16'h0E70,
        16'h0651, 16'h0E61, 16'h1E61, 16'h0230,
        16'h1E71, 16'h0E71, 16'h1671, 16'h4E34,
        16'h1821, 16'h4A34, 16'h1061, 16'h1861
    };

    // The lit window must fit inside a slot after the blanking interval.
    function automatic bit seg14_params_ok(
        input int unsigned n_digits,
        input int unsigned scan_div,
        input int unsigned dead_cyc,
        input int unsigned pwm_bits
    );
        return (n_digits >= 1) && (n_digits <= 8) &&
               (pwm_bits >= 1) && (pwm_bits <= 16) &&
               (scan_div >= 2) &&
               (scan_div >= dead_cyc + (32'd1 << pwm_bits));
    endfunction

endpackage

// File: rtl/seg14_glyph_rom.sv
// Combinational hex nibble to 14-segment (16-bit) glyph decode.
module seg14_glyph_rom
    import seg14_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg14_t     o_glyph
);

    assign o_glyph = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/seg14_scan_driver.sv
// Multiplexed 14-segment display scanner with per-slot PWM dimming and
// frame-synchronous double-buffered loading.
module seg14_scan_driver
    import seg14_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned DEAD_CYC = 16,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*N_DIGITS-1:0] load_hex,
    input  logic [N_DIGITS-1:0]   load_blank,
    input  logic [PWM_BITS-1:0]   bright,
    output seg14_t                seg,
    output logic [N_DIGITS-1:0]   dig_en
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if (!seg14_params_ok(N_DIGITS, SCAN_DIV, DEAD_CYC, PWM_BITS)) begin : g_param_check
        $error("seg14_scan_driver: SCAN_DIV must cover DEAD_CYC + 2**PWM_BITS, N_DIGITS 1..8");
    end

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_disp_hex;
    logic [N_DIGITS-1:0]   r_disp_blank;
    logic [4*N_DIGITS-1:0] r_pend_hex;
    logic [N_DIGITS-1:0]   r_pend_blank;
    logic                  r_pend_valid;
    seg14_t                r_seg;
    logic [N_DIGITS-1:0]   r_dig_en;

    logic                  w_tick;
    logic                  w_last_digit;
    logic                  w_boundary;
    logic                  w_accept;
    logic [3:0]            w_nibble;
    logic                  w_blank;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [31:0]           w_cnt32;
    logic                  w_lit;
    seg14_t                w_glyph;

    assign w_tick       = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_last_digit = (r_idx == IDX_W'(N_DIGITS - 1));
    assign w_boundary   = w_tick && w_last_digit;
    // Ready is purely registered; valid is only looked at while ready is high.
    assign load_ready   = ~r_pend_valid;
    assign w_accept     = load_valid && !r_pend_valid;

    always_comb begin
        w_nibble = 4'd0;
        w_blank  = 1'b0;
        w_onehot = '0;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_nibble    = r_disp_hex[4*d +: 4];
                w_blank     = r_disp_blank[d];
                w_onehot[d] = 1'b1;
            end
        end
    end

    seg14_glyph_rom u_glyph_rom (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

    assign w_cnt32 = 32'(r_cnt);
    assign w_lit   = (w_cnt32 >= DEAD_CYC) && (w_cnt32 < DEAD_CYC + 32'(bright)) && !w_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= w_last_digit ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A capture on a boundary cycle leaves r_pend_valid low there, so it waits a full frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_hex   <= '0;
            r_pend_blank <= '0;
            r_disp_hex   <= '0;
            r_disp_blank <= '0;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_hex   <= load_hex;
            r_pend_blank <= load_blank;
        end else if (r_pend_valid && w_boundary) begin
            r_pend_valid <= 1'b0;
            r_disp_hex   <= r_pend_hex;
            r_disp_blank <= r_pend_blank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg    <= '0;
            r_dig_en <= '0;
        end else begin
            r_seg    <= w_lit ? w_glyph : '0;
            r_dig_en <= w_lit ? w_onehot : '0;
        end
    end

    assign seg    = r_seg;
    assign dig_en = r_dig_en;

endmodule

// File: tb/tb_seg14_scan_driver.sv
// Directed self-checking bench for seg14_scan_driver at default parameters.
module tb_seg14_scan_driver;

    localparam int SLOT  = 1024;
    localparam int FRAME = 4 * SLOT;

    localparam logic [15:0] G0 = 16'h3AB1;
    localparam logic [15:0] G1 = 16'h0290;
    localparam logic [15:0] G2 = 16'h1C70;
    localparam logic [15:0] G3 = 16'h0E70;
    localparam logic [15:0] G4 = 16'h0651;
    localparam logic [15:0] G5 = 16'h0E61;
    localparam logic [15:0] G8 = 16'h1E71;
    localparam logic [15:0] GA = 16'h1671;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_hex;
    logic [3:0]  load_blank;
    logic [7:0]  bright;
    logic [15:0] seg;
    logic [3:0]  dig_en;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    int          len_a   [4];
    int          first_a [4];
    logic [15:0] seg_a   [4];
    int          bad_cnt;

    seg14_scan_driver #(
        .N_DIGITS (4),
        .SCAN_DIV (1024),
        .DEAD_CYC (16),
        .PWM_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_hex   (load_hex),
        .load_blank (load_blank),
        .bright     (bright),
        .seg        (seg),
        .dig_en     (dig_en)
    );

    always #5 clk = ~clk;

    // Edges since reset release: after edge k the scanner sits at cnt=k%1024.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int next_boundary(input int c);
        return (c / FRAME + 1) * FRAME;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Offer a frame and hold it until accepted; cap = edge number of the handshake.
    task automatic send(input string tag, input logic [15:0] hex, input logic [3:0] blank,
                        input int budget, output int cap);
        bit accepted = 1'b0;
        cap = -1;
        @(negedge clk);
        load_valid = 1'b1;
        load_hex   = hex;
        load_blank = blank;
        for (int i = 0; i < budget; i++) begin
            if (load_ready) begin
                cap      = cyc + 1;
                accepted = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        check({tag, "_accepted"}, 32'(accepted), 32'd1);
    endtask

    // Record one whole frame of outputs, aligned so sample j shows scanner state j.
    task automatic observe_frame();
        for (int d = 0; d < 4; d++) begin
            len_a[d]   = 0;
            first_a[d] = -1;
            seg_a[d]   = '0;
        end
        bad_cnt = 0;
        while (cyc % FRAME != 1) @(negedge clk);
        for (int j = 0; j < FRAME; j++) begin
            for (int d = 0; d < 4; d++) begin
                if (dig_en[d]) begin
                    if (d != j / SLOT) bad_cnt++;
                    if (first_a[d] < 0) begin
                        first_a[d] = cyc % SLOT;
                        seg_a[d]   = seg;
                    end else if (seg !== seg_a[d]) begin
                        bad_cnt++;
                    end
                    len_a[d]++;
                end
            end
            if (dig_en == 4'd0 && seg !== 16'd0) bad_cnt++;
            if ($countones(dig_en) > 1) bad_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp_seg,
                               input logic [3:0] lit, input int exp_len);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s_len%0d", tag, d), len_a[d], lit[d] ? exp_len : 0);
            if (lit[d] && exp_len > 0) begin
                check($sformatf("%s_start%0d", tag, d), first_a[d], 32'd17);
                check($sformatf("%s_seg%0d", tag, d), 32'(seg_a[d]), 32'(exp_seg[16*d +: 16]));
            end
        end
        check({tag, "_stray"}, bad_cnt, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int cap;
        int cap2;
        int apply;

        rst        = 1'b1;
        load_valid = 1'b0;
        load_hex   = '0;
        load_blank = '0;
        bright     = 8'd255;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 0);
        check("rst_dig_en", 32'(dig_en), 0);
        check("rst_ready", 32'(load_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Load 0x1234 at full brightness
        send("t1", 16'h1234, 4'b0000, 10, cap);
        check("t1_ready_drop", 32'(load_ready), 0);
        apply = next_boundary(cap);
        wait_cyc(apply - 1);
        check("t1_ready_before_bnd", 32'(load_ready), 0);
        wait_cyc(apply);
        check("t1_ready_after_bnd", 32'(load_ready), 1);
        observe_frame();
        check_frame("t1", {G1, G2, G3, G4}, 4'hF, 255);

        // Back-to-back loads: the second stalls until the first is displayed
        send("t2a", 16'hAAAA, 4'b0000, 10, cap);
        send("t2b", 16'h5555, 4'b0000, 6000, cap2);
        check("t2_stall_cap", cap2, next_boundary(cap) + 1);
        check("t2_ready_pending", 32'(load_ready), 0);
        observe_frame();
        check_frame("t2a", {GA, GA, GA, GA}, 4'hF, 255);
        observe_frame();
        check_frame("t2b", {G5, G5, G5, G5}, 4'hF, 255);

        // Blank mask 0101
        send("t3", 16'h8888, 4'b0101, 10, cap);
        wait_cyc(next_boundary(cap));
        observe_frame();
        check_frame("t3", {G8, G8, G8, G8}, 4'b1010, 255);

        // bright=0 dark for three frames, then bright=1
        send("t4", 16'h8888, 4'b0000, 10, cap);
        bright = 8'd0;
        wait_cyc(next_boundary(cap));
        for (int f = 0; f < 3; f++) begin
            observe_frame();
            check_frame($sformatf("t4_dark%0d", f), '0, 4'h0, 0);
        end
        bright = 8'd1;
        observe_frame();
        check_frame("t4_b1", {G8, G8, G8, G8}, 4'hF, 1);

        // Handshake exactly on the boundary edge
        bright = 8'd200;
        while (cyc % FRAME != FRAME - 2) @(negedge clk);
        send("t5", 16'h3333, 4'b0000, 10, cap);
        check("t5_cap_on_bnd", cap % FRAME, 0);
        check("t5_ready_pending", 32'(load_ready), 0);
        observe_frame();
        check_frame("t5_old", {G8, G8, G8, G8}, 4'hF, 200);
        check("t5_ready_applied", 32'(load_ready), 1);
        observe_frame();
        check_frame("t5_new", {G3, G3, G3, G3}, 4'hF, 200);

        // Reset mid-slot with a frame pending
        send("t6", 16'h9999, 4'b0000, 10, cap);
        while (cyc % SLOT != 100) @(negedge clk);
        check("t6_lit_before_rst", 32'(dig_en != 4'd0), 1);
        check("t6_pending", 32'(load_ready), 0);
        rst = 1'b1;
        #1;
        check("t6_rst_seg", 32'(seg), 0);
        check("t6_rst_dig_en", 32'(dig_en), 0);
        check("t6_rst_ready", 32'(load_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        observe_frame();
        check_frame("t6_f0", {G0, G0, G0, G0}, 4'hF, 200);
        observe_frame();
        check_frame("t6_f1", {G0, G0, G0, G0}, 4'hF, 200);
        check("t6_ready_end", 32'(load_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg14_scan_driver.md
SEG14_SCAN_DRIVER -- requirements
Module: seg14_scan_driver

Interface
REQ-001 The block SHALL have the parameter N_DIGITS, default 4, giving the number of multiplexed 14-segment digits (legal range 1..8).
REQ-002 The block SHALL have the parameter SCAN_DIV, default 1024, giving clock cycles per digit slot.
REQ-003 The block SHALL have the parameter DEAD_CYC, default 16, giving the blanking cycles at the start of each slot.
REQ-004 The block SHALL have the parameter PWM_BITS, default 8, giving the brightness width; elaboration SHALL fail unless SCAN_DIV >= DEAD_CYC + 2^PWM_BITS.
REQ-005 Port clk, input, 1 bit: the single clock.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port load_valid, input, 1 bit: a new frame is offered.
REQ-008 Port load_ready, output, 1 bit: the block can accept a frame.
REQ-009 Port load_hex, input, 4*N_DIGITS bits: hex nibbles, digit 0 in [3:0].
REQ-010 Port load_blank, input, N_DIGITS bits: per-digit blank mask, 1 = digit dark.
REQ-011 Port bright, input, PWM_BITS bits: on-cycles per slot, sampled live.
REQ-012 Port seg, output, 16 bits: segment lines for the active digit.
REQ-013 Port dig_en, output, N_DIGITS bits: active-high digit enables, at most one bit high.

Function
REQ-014 The prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be defined as cnt==SCAN_DIV-1.
REQ-015 The digit index idx SHALL increment on tick and wrap from N_DIGITS-1 to 0; frame boundary = tick AND idx==N_DIGITS-1.
REQ-016 A handshake SHALL occur when load_valid AND load_ready; load_hex and load_blank SHALL be captured into a pending register and load_ready SHALL drop the following cycle.
REQ-017 On the first frame boundary after capture (excluding a boundary in the capture cycle itself), pending SHALL be copied to the display register and load_ready SHALL rise the next cycle; no tearing within a frame.
REQ-018 A handshake coinciding with a boundary SHALL be applied at the next boundary.
REQ-019 While load_ready is low, load_valid SHALL be ignored; load_ready SHALL NOT depend combinationally on load_valid.
REQ-020 Glyphs SHALL be decoded as hex 0..F -> 0x3AB1, 0x0290, 0x1C70, 0x0E70, 0x0651, 0x0E61, 0x1E61, 0x0230, 0x1E71, 0x0E71, 0x1671, 0x4E34, 0x1821, 0x4A34, 0x1061, 0x1861.
REQ-021 A digit SHALL be lit when DEAD_CYC <= cnt < DEAD_CYC+bright and its blank bit is 0; lit means dig_en[idx]=1 and seg=glyph(idx); otherwise dig_en=0 and seg=0.
REQ-022 seg and dig_en SHALL be registered, lagging cnt/idx by exactly one clock.
REQ-023 bright=0 SHALL give a permanently dark display; the maximum bright value SHALL still leave DEAD_CYC dark cycles per slot.

Reset
REQ-024 Asserting rst SHALL immediately force cnt=0, idx=0, display=0 (all digits unblanked, showing "0"), pending empty, load_ready=1, seg=0 and dig_en=0.
REQ-025 Reset asserted mid-frame SHALL discard any pending frame; after release, the first lit cycle SHALL occur on the clock edge DEAD_CYC+1 edges later.

Structure
REQ-026 Package seg14_pkg SHALL hold the 16-entry glyph constant table, the 16-bit segment type, and the parameter-legality function.
REQ-027 Sub-module seg14_glyph_rom SHALL provide the combinational nibble->16-bit decode from the package table; the scan, PWM and handshake logic SHALL remain in seg14_scan_driver.

Verification
REQ-028 The bench SHALL cover: N=4, SCAN_DIV=1024, DEAD=16, bright=255, load 0x1234 -> after the boundary, slot 0 shows seg=0x0651, slot 3 shows seg=0x0290, and each dig_en pulse is 255 cycles starting at cnt=17.
REQ-029 The bench SHALL cover: two loads back-to-back (0xAAAA, then 0x5555 while load_ready=0) -> the second is stalled, 0xAAAA is displayed a full frame, then the second is accepted.
REQ-030 The bench SHALL cover: load_blank=4'b0101 -> dig_en[0] and dig_en[2] are never high and seg=0 in those slots.
REQ-031 The bench SHALL cover: bright=0 -> dig_en stays 0 for 3 frames; then bright=1 -> exactly a 1-cycle pulse per slot.
REQ-032 The bench SHALL cover: handshake exactly on the boundary cycle -> the display changes at the following boundary (one frame later).
REQ-033 The bench SHALL cover: rst pulse mid-slot with a pending frame -> outputs are 0 immediately, load_ready=1, and the display shows "0000".
